// File: rtl/m6800_slave_if.sv
// 6800-style synchronous bus signals between the 68000 bus emulator (master)
// and a peripheral responder (slave).
interface m6800_slave_if;
    logic        E;
    logic        AS_CPU_n;
    logic        CPUSPACE;
    logic        RW;
    logic [23:1] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        VPA_n;
    logic        VMA_n;

    modport slave (
        input  E, AS_CPU_n, CPUSPACE, RW, A, D_IN, VMA_n,
        output D_OUT, D_OE, VPA_n
    );

    modport master (
        output E, AS_CPU_n, CPUSPACE, RW, A, D_IN, VMA_n,
        input  D_OUT, D_OE, VPA_n
    );
endinterface

// File: rtl/m6800_slave.sv
// 6800 synchronous-bus responder with an 8-bit register file, clocked on C7M.
// Define M6800_SLAVE_IRQ_EN to add the ISR/IMR interrupt block and the IRQ_SRC port.
module m6800_slave #(
    parameter int               DEC_W = 8,
    parameter logic [DEC_W-1:0] BASE  = 8'hBF,
    parameter int               NREGS = 16
) (
    input  logic               C7M,
    input  logic               RESET,
    m6800_slave_if.slave       bus,
`ifdef M6800_SLAVE_IRQ_EN
    input  logic [7:0]         IRQ_SRC,
`endif
    output logic [8*NREGS-1:0] REGS,
    output logic               INT2_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t     state_q;
    logic       vpa_n_q;
    logic       d_oe_q;
    logic [7:0] d_out_q;
    logic [3:0] idx_q;
    logic       rw_q;
    logic       e_meta_q;
    logic       e_sync_q;
    logic       e_prev_q;

    logic       e_rise;
    logic       e_fall;
    logic       hit;
    logic [3:0] idx_d;
    logic [7:0] rd_data;
    logic       wr_stb;
    logic       rd_stb;
    logic       unused_addr;

    logic [7:0] reg_vals [NREGS];

    assign e_rise = e_sync_q & ~e_prev_q;
    assign e_fall = ~e_sync_q & e_prev_q;

    assign hit   = ~bus.AS_CPU_n & ~bus.CPUSPACE & (bus.A[23:24-DEC_W] == BASE);
    assign idx_d = bus.A[4:1];
    assign unused_addr = ^bus.A;

    // Register strobes fire on E_fall even if AS is released on the same edge.
    assign wr_stb = (state_q == S_ACCESS) & e_fall & ~rw_q;
    assign rd_stb = (state_q == S_ACCESS) & e_fall & rw_q;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx_d == 4'(i)) begin
                rd_data = reg_vals[i];
            end
        end
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            vpa_n_q  <= 1'b1;
            d_oe_q   <= 1'b0;
            d_out_q  <= '0;
            idx_q    <= '0;
            rw_q     <= 1'b1;
            e_meta_q <= 1'b0;
            e_sync_q <= 1'b0;
            e_prev_q <= 1'b0;
        end else begin
            e_meta_q <= bus.E;
            e_sync_q <= e_meta_q;
            e_prev_q <= e_sync_q;

            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        state_q <= S_DECODE;
                        vpa_n_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (bus.AS_CPU_n) begin
                        state_q <= S_IDLE;
                        vpa_n_q <= 1'b1;
                    end else if (!bus.VMA_n && e_rise) begin
                        state_q <= S_ACCESS;
                        idx_q   <= idx_d;
                        rw_q    <= bus.RW;
                        if (bus.RW) begin
                            d_out_q <= rd_data;
                            d_oe_q  <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (e_fall) begin
                        if (bus.AS_CPU_n) begin
                            state_q <= S_IDLE;
                            vpa_n_q <= 1'b1;
                            d_oe_q  <= 1'b0;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end else if (bus.AS_CPU_n) begin
                        state_q <= S_IDLE;
                        vpa_n_q <= 1'b1;
                        d_oe_q  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (bus.AS_CPU_n) begin
                        state_q <= S_IDLE;
                        vpa_n_q <= 1'b1;
                        d_oe_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    vpa_n_q <= 1'b1;
                    d_oe_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.VPA_n = vpa_n_q;
    assign bus.D_OE  = d_oe_q;
    assign bus.D_OUT = d_out_q;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [7:0] reg_q;
            logic       sel;

            assign sel = (idx_q == 4'(gi));

`ifdef M6800_SLAVE_IRQ_EN
            if (gi == NREGS - 2) begin : g_isr
                // Sticky status: new sources OR in after the read-clear, so a set wins.
                always_ff @(posedge C7M) begin
                    if (RESET) begin
                        reg_q <= '0;
                    end else begin
                        reg_q <= ((rd_stb && sel) ? 8'h00 : reg_q) | IRQ_SRC;
                    end
                end
            end else begin : g_rw
                always_ff @(posedge C7M) begin
                    if (RESET) begin
                        reg_q <= '0;
                    end else if (wr_stb && sel) begin
                        reg_q <= bus.D_IN;
                    end
                end
            end
`else
            always_ff @(posedge C7M) begin
                if (RESET) begin
                    reg_q <= '0;
                end else if (wr_stb && sel) begin
                    reg_q <= bus.D_IN;
                end
            end
`endif

            assign reg_vals[gi]    = reg_q;
            assign REGS[8*gi +: 8] = reg_q;
        end
    endgenerate

`ifdef M6800_SLAVE_IRQ_EN
    logic int2_n_q;

    always_ff @(posedge C7M) begin
        if (RESET) begin
            int2_n_q <= 1'b1;
        end else begin
            int2_n_q <= ~|(reg_vals[NREGS-2] & reg_vals[NREGS-1]);
        end
    end

    assign INT2_n = int2_n_q;
`else
    logic unused_rd_stb;
    assign unused_rd_stb = rd_stb;
    assign INT2_n = 1'b1;
`endif

endmodule
